logic_unit_pipe: RTL and testbench

Parametrised, registered bitwise logic unit; successor to the fixed 8-bit combinational OR gate.
- Computes one of eight bitwise operations on two WIDTH-bit operands behind a valid/ready handshake.
- Output is registered, giving one cycle of latency.
- Optionally folds a multi-beat burst into one reduced result.
- Sits on the datapath between operand sources and any stream consumer that may stall.

---
 rtl/logic_unit_pkg.sv | 50 +++++
 rtl/logic_unit_pipe_if.sv | 35 +++
 rtl/logic_unit_core.sv | 50 +++++
 rtl/logic_unit_pipe.sv | 149 ++++++++++++++
 tb/tb_logic_unit_pipe.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
// Shared types and helpers for the registered bitwise logic unit.
//   op_e        : 3-bit operation select (AND .. NOT_A)
//   state_e     : burst FSM states (only used when LOGIC_UNIT_REDUCE_EN is defined)
//   fold_base_e : the non-inverting operation an op folds with across a burst
//   base_of()   : maps an op to its fold base
//   is_inverting(): true for ops whose inversion is applied only to the emitted result
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_XOR    = 3'b010,
    OP_NAND   = 3'b011,
    OP_NOR    = 3'b100,
    OP_XNOR   = 3'b101,
    OP_PASS_A = 3'b110,
    OP_NOT_A  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    FB_AND     = 2'd0,
    FB_OR      = 2'd1,
    FB_XOR     = 2'd2,
    FB_REPLACE = 2'd3
  } fold_base_e;

  // Inverting ops share the base of their non-inverting partner so a burst
  // can be folded with the plain operation and inverted once at the end.
  function automatic fold_base_e base_of(input op_e op);
    fold_base_e fb;
    case (op)
      OP_AND, OP_NAND:      fb = FB_AND;
      OP_OR, OP_NOR:        fb = FB_OR;
      OP_XOR, OP_XNOR:      fb = FB_XOR;
      default:              fb = FB_REPLACE;
    endcase
    return fb;
  endfunction

  function automatic logic is_inverting(input op_e op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR) || (op == OP_NOT_A);
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if
// Stream bundle for logic_unit_pipe: operand beat channel in, result channel out.
//   in_valid/in_ready      : operand beat handshake
//   a, b, op, acc, last    : operand beat payload
//   out_valid/out_ready    : result handshake
//   y, zero                : result payload (zero flags y == 0)
// modport master : operand source / result consumer side
// modport slave  : the logic unit itself
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;

  modport master (
    output in_valid, a, b, op, acc, last, out_ready,
    input  in_ready, out_valid, y, zero
  );

  modport slave (
    input  in_valid, a, b, op, acc, last, out_ready,
    output in_ready, out_valid, y, zero
  );

endinterface

// File: rtl/logic_unit_core.sv
// logic_unit_core
// Combinational base operation and fold for the logic unit.
//   op_i       : operation; only its fold base matters here
//   a_i, b_i   : operands
//   accum_i    : running burst accumulator
//   useAccum_i : 1 = fold base(a,b) into accum_i, 0 = return base(a,b) alone
//   folded_o   : non-inverted result; the caller applies any final inversion
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] accum_i,
  input  logic             useAccum_i,
  output logic [WIDTH-1:0] folded_o
);

  logic [WIDTH-1:0] baseVal;
  logic [WIDTH-1:0] foldVal;

  // Evaluate the op's base on the fresh operands, then combine it with the
  // accumulator using the same base. REPLACE simply keeps the newest beat.
  always_comb begin
    baseVal = a_i;
    foldVal = a_i;
    case (base_of(op_i))
      FB_AND: begin
        baseVal = a_i & b_i;
        foldVal = accum_i & baseVal;
      end
      FB_OR: begin
        baseVal = a_i | b_i;
        foldVal = accum_i | baseVal;
      end
      FB_XOR: begin
        baseVal = a_i ^ b_i;
        foldVal = accum_i ^ baseVal;
      end
      default: begin
        baseVal = a_i;
        foldVal = baseVal;
      end
    endcase
    folded_o = useAccum_i ? foldVal : baseVal;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
// Registered WIDTH-bit bitwise logic unit behind a valid/ready handshake.
// One cycle of latency, one beat per cycle while the consumer keeps up.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : logic_unit_pipe_if.slave (operand beat in, result out)
// Optional feature macro: LOGIC_UNIT_REDUCE_EN
//   defined   -> acc/last bursts are folded into one result by an IDLE/ACCUM FSM
//   undefined -> acc/last are ignored and every beat produces its own result
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  logic_unit_pipe_if.slave bus
);

  logic             inReady;
  logic             beatFire;
  logic             outFire;
  op_e              opIn;
  op_e              coreOp;
  logic             useAccum;
  logic             emit;
  logic [WIDTH-1:0] accumIn;
  logic [WIDTH-1:0] coreOut;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_d;
  logic             zero_q;
  logic             zero_d;
  logic             outValid_q;
  logic             outValid_d;

  assign opIn     = op_e'(bus.op);
  assign inReady  = !outValid_q || bus.out_ready;
  assign beatFire = bus.in_valid && inReady;
  assign outFire  = outValid_q && bus.out_ready;

`ifdef LOGIC_UNIT_REDUCE_EN
  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] accum_q;
  logic [WIDTH-1:0] accum_d;
  op_e              opQ_q;
  op_e              opQ_d;

  assign useAccum = (state_q == ST_ACCUM);
  assign coreOp   = useAccum ? opQ_q : opIn;
  assign accumIn  = accum_q;
  // In IDLE only an opening burst beat (acc=1, last=0) is swallowed; in ACCUM
  // only the last beat produces a result.
  assign emit     = beatFire && (useAccum ? bus.last : !(bus.acc && !bus.last));

  // Burst FSM next state. The first beat seeds the accumulator with the base
  // result and records the op; later beats reuse that op and fold in.
  always_comb begin
    state_d = state_q;
    accum_d = accum_q;
    opQ_d   = opQ_q;
    if (beatFire) begin
      if (state_q == ST_IDLE) begin
        if (bus.acc && !bus.last) begin
          state_d = ST_ACCUM;
          opQ_d   = opIn;
          accum_d = coreOut;
        end
      end else if (bus.last) begin
        state_d = ST_IDLE;
        accum_d = '0;
      end else begin
        accum_d = coreOut;
      end
    end
  end

  // Burst state registers; reset discards any partial accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      accum_q <= '0;
      opQ_q   <= OP_AND;
    end else begin
      state_q <= state_d;
      accum_q <= accum_d;
      opQ_q   <= opQ_d;
    end
  end
`else
  logic unusedBurstBits;
  assign unusedBurstBits = bus.acc ^ bus.last;

  assign useAccum = 1'b0;
  assign coreOp   = opIn;
  assign accumIn  = '0;
  assign emit     = beatFire;
`endif

  logic_unit_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op_i       (coreOp),
    .a_i        (bus.a),
    .b_i        (bus.b),
    .accum_i    (accumIn),
    .useAccum_i (useAccum),
    .folded_o   (coreOut)
  );

  assign result = is_inverting(coreOp) ? ~coreOut : coreOut;

  // Output register next state. A new result wins over a drain in the same
  // cycle, so simultaneous in/out transfer keeps out_valid high. While the
  // consumer stalls, inReady is low, emit cannot fire and y/zero hold.
  always_comb begin
    y_d        = y_q;
    zero_d     = zero_q;
    outValid_d = outValid_q;
    if (emit) begin
      y_d        = result;
      zero_d     = (result == '0);
      outValid_d = 1'b1;
    end else if (outFire) begin
      outValid_d = 1'b0;
    end
  end

  // Output registers; zero comes out of reset set to match y = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q        <= '0;
      zero_q     <= 1'b1;
      outValid_q <= 1'b0;
    end else begin
      y_q        <= y_d;
      zero_q     <= zero_d;
      outValid_q <= outValid_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe
// Directed bench for logic_unit_pipe: an 8-bit instance for handshake, stall
// and burst behaviour, and a 16-bit instance for an all-op sweep.
// Burst steps depend on LOGIC_UNIT_REDUCE_EN, matching the DUT build.
module tb_logic_unit_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic_unit_pipe_if #(.WIDTH(8))  if8 ();
  logic_unit_pipe_if #(.WIDTH(16)) if16 ();

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  logic_unit_pipe #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for the 16-bit sweep, written from the op table.
  function automatic logic [15:0] refOp(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~(a & b);
      3'b100:  r = ~(a | b);
      3'b101:  r = ~(a ^ b);
      3'b110:  r = a;
      default: r = ~a;
    endcase
    return r;
  endfunction

  // Drive one operand beat plus the consumer ready on the 8-bit instance.
  task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op, input logic acc, input logic last,
                               input logic outReady);
    if8.in_valid  = valid;
    if8.a         = a;
    if8.b         = b;
    if8.op        = op;
    if8.acc       = acc;
    if8.last      = last;
    if8.out_ready = outReady;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] sa;
    logic [15:0] sb;
    logic [15:0] sy;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);
    if16.in_valid  = 1'b0;
    if16.a         = '0;
    if16.b         = '0;
    if16.op        = 3'b000;
    if16.acc       = 1'b0;
    if16.last      = 1'b0;
    if16.out_ready = 1'b1;

    // Reset state
    #1;
    checkOutput("rst_out_valid", {31'd0, if8.out_valid}, 32'd0);
    checkOutput("rst_y",         {24'd0, if8.y},         32'h00);
    checkOutput("rst_zero",      {31'd0, if8.zero},      32'd1);
    checkOutput("rst_in_ready",  {31'd0, if8.in_ready},  32'd1);
    tick();
    tick();
    rst = 1'b0;

    // OR beat, then a back-to-back OR beat
    applyStimulus(1'b1, 8'b00011100, 8'b00010001, 3'b001, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("or1_out_valid", {31'd0, if8.out_valid}, 32'd1);
    checkOutput("or1_y",         {24'd0, if8.y},         32'b00011101);
    checkOutput("or1_zero",      {31'd0, if8.zero},      32'd0);
    checkOutput("or1_in_ready",  {31'd0, if8.in_ready},  32'd1);
    applyStimulus(1'b1, 8'b10110010, 8'b11110100, 3'b001, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("or2_y",         {24'd0, if8.y},         32'b11110110);
    checkOutput("or2_out_valid", {31'd0, if8.out_valid}, 32'd1);
    checkOutput("or2_in_ready",  {31'd0, if8.in_ready},  32'd1);

    // AND to zero, then stall the consumer for 3 cycles with a beat waiting
    applyStimulus(1'b1, 8'hF0, 8'h0F, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("and_y",    {24'd0, if8.y},    32'h00);
    checkOutput("and_zero", {31'd0, if8.zero}, 32'd1);
    applyStimulus(1'b1, 8'h0F, 8'h33, 3'b010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_y",         {24'd0, if8.y},         32'h00);
      checkOutput("stall_zero",      {31'd0, if8.zero},      32'd1);
      checkOutput("stall_out_valid", {31'd0, if8.out_valid}, 32'd1);
      checkOutput("stall_in_ready",  {31'd0, if8.in_ready},  32'd0);
    end

    // Release the stall: output and input transfer in the same cycle
    if8.out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", {31'd0, if8.in_ready}, 32'd1);
    tick();
    checkOutput("swap_y",         {24'd0, if8.y},         32'h3C);
    checkOutput("swap_zero",      {31'd0, if8.zero},      32'd0);
    checkOutput("swap_out_valid", {31'd0, if8.out_valid}, 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("drain_out_valid", {31'd0, if8.out_valid}, 32'd0);

    // acc=1 with last=1 always behaves as a single beat (NAND)
    applyStimulus(1'b1, 8'hCC, 8'hAA, 3'b011, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("acc_last_y", {24'd0, if8.y}, 32'h77);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();

`ifdef LOGIC_UNIT_REDUCE_EN
    // NOR burst of three beats; op change mid-burst is ignored
    applyStimulus(1'b1, 8'h01, 8'h00, 3'b100, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("burst_b1_out_valid", {31'd0, if8.out_valid}, 32'd0);
    applyStimulus(1'b1, 8'h02, 8'h00, 3'b000, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("burst_b2_out_valid", {31'd0, if8.out_valid}, 32'd0);
    applyStimulus(1'b1, 8'h00, 8'h80, 3'b000, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("burst_y",         {24'd0, if8.y},         32'h7C);
    checkOutput("burst_out_valid", {31'd0, if8.out_valid}, 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();

    // XOR burst interrupted by reset; the partial fold must vanish
    applyStimulus(1'b1, 8'h11, 8'h22, 3'b010, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'h44, 8'h08, 3'b010, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
`else
    // Without the reduce feature an opening burst beat still emits (NOR)
    applyStimulus(1'b1, 8'h01, 8'h00, 3'b100, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("noreduce_y",         {24'd0, if8.y},         32'hFE);
    checkOutput("noreduce_out_valid", {31'd0, if8.out_valid}, 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
`endif
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {31'd0, if8.out_valid}, 32'd0);
    checkOutput("midrst_zero",      {31'd0, if8.zero},      32'd1);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 8'hAA, 8'hFF, 3'b010, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("post_rst_y",         {24'd0, if8.y},         32'h55);
    checkOutput("post_rst_out_valid", {31'd0, if8.out_valid}, 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);

    // 16-bit sweep over all op codes with random operands, one beat per cycle
    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 3; k++) begin
        sa = 16'($urandom);
        sb = 16'($urandom);
        sy = refOp(3'(op), sa, sb);
        if16.in_valid = 1'b1;
        if16.a        = sa;
        if16.b        = sb;
        if16.op       = 3'(op);
        tick();
        checkOutput($sformatf("sweep_op%0d_y", op),    {16'd0, if16.y},         {16'd0, sy});
        checkOutput($sformatf("sweep_op%0d_zero", op), {31'd0, if16.zero},      {31'd0, (sy == 16'h0000)});
        checkOutput($sformatf("sweep_op%0d_vld", op),  {31'd0, if16.out_valid}, 32'd1);
      end
    end
    if16.in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
